// File: rtl/feedback_frame_decoder.sv
// Decodes GenshinKitchen feedback bytes from the UART receiver into
// debounced status flags, with link-stale detection and a bad-byte counter.
module feedback_frame_decoder #(
   parameter int CONFIRM_CNT    = 2,
   parameter int TIMEOUT_CYCLES = 153600,
   parameter int CNT_W          = 18
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             data_valid,
   input  logic [7:0]       data_receive,
   input  logic             script_mode,
   output logic             sig_front,
   output logic             sig_hand,
   output logic             sig_processing,
   output logic             sig_machine,
   output logic [3:0]       feedback_leds,
   output logic             fb_update,
   output logic             fb_stale,
   output logic [7:0]       err_count
);

   localparam int MW = (CONFIRM_CNT < 2) ? 1 : $clog2(CONFIRM_CNT + 1);
   localparam logic [MW-1:0]    TARGET   = MW'(CONFIRM_CNT);
   localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TIMEOUT_CYCLES);
   localparam bit               ONE_SHOT = (CONFIRM_CNT == 1);

   typedef enum logic [1:0] {EMPTY, TRACK, LOCKED} state_t;

   state_t           state;
   logic             prev_valid;
   logic [7:0]       s1_data;
   logic             s1_acc;
   logic [3:0]       cand;
   logic [MW-1:0]    cnt;
   logic [3:0]       sigs;
   logic [CNT_W-1:0] timer;

   logic       accept;
   logic       live;
   logic       is_fb;
   logic       frame;
   logic       bad;
   logic [3:0] payload;
   logic       start_en;
   logic       commit_en;
   logic       bump_en;
   logic       unused_bits;

   assign accept      = data_valid & ~prev_valid & ~script_mode;
   assign live        = s1_acc & ~script_mode;
   assign is_fb       = (s1_data[1:0] == 2'b01);
   assign frame       = live & is_fb;
   assign bad         = live & ~is_fb;
   assign payload     = s1_data[5:2];
   assign unused_bits = ^s1_data[7:6];

   always_comb begin
      start_en  = 1'b0;
      commit_en = 1'b0;
      bump_en   = 1'b0;
      if (frame) begin
         unique case (state)
            TRACK: begin
               if (payload == cand) begin
                  if ((cnt + MW'(1)) == TARGET) commit_en = 1'b1;
                  else                          bump_en   = 1'b1;
               end else begin
                  start_en = 1'b1;
               end
            end
            LOCKED:  start_en = (payload != sigs);
            default: start_en = 1'b1;
         endcase
      end
      // A single-frame confirm commits straight from a fresh candidate
      if (start_en && ONE_SHOT) begin
         start_en  = 1'b0;
         commit_en = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= EMPTY;
         prev_valid <= 1'b0;
         s1_data    <= '0;
         s1_acc     <= 1'b0;
         cand       <= '0;
         cnt        <= '0;
         sigs       <= '0;
         timer      <= '0;
         fb_update  <= 1'b0;
         fb_stale   <= 1'b1;
         err_count  <= '0;
      end else begin
         prev_valid <= data_valid;
         s1_data    <= data_receive;
         s1_acc     <= accept;
         fb_update  <= 1'b0;

         if (bad && err_count != 8'hFF)
            err_count <= err_count + 8'd1;

         if (script_mode) begin
            state <= EMPTY;
            cnt   <= '0;
         end else if (frame) begin
            timer    <= '0;
            fb_stale <= 1'b0;
            if (commit_en) begin
               sigs      <= payload;
               fb_update <= (payload != sigs);
               cand      <= payload;
               cnt       <= '0;
               state     <= LOCKED;
            end else if (start_en) begin
               cand  <= payload;
               cnt   <= MW'(1);
               state <= TRACK;
            end else if (bump_en) begin
               cnt <= cnt + MW'(1);
            end
         end else if (timer != LIMIT) begin
            timer <= timer + CNT_W'(1);
            if (timer == LIMIT - CNT_W'(1))
               fb_stale <= 1'b1;
         end
      end
   end

   assign sig_front      = sigs[0];
   assign sig_hand       = sigs[1];
   assign sig_processing = sigs[2];
   assign sig_machine    = sigs[3];
   assign feedback_leds  = sigs;

endmodule

// File: tb/tb_feedback_frame_decoder.sv
// Directed bench for feedback_frame_decoder: vector table for frame decoding,
// hand sequences for hold, timeout, saturation, script mode and reset.
module tb_feedback_frame_decoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       data_valid = 1'b0;
   logic [7:0] data_receive = '0;
   logic       script_mode = 1'b0;
   logic       sig_front, sig_hand, sig_processing, sig_machine;
   logic [3:0] feedback_leds;
   logic       fb_update, fb_stale;
   logic [7:0] err_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   feedback_frame_decoder #(
      .CONFIRM_CNT   (2),
      .TIMEOUT_CYCLES(16),
      .CNT_W         (5)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .data_valid    (data_valid),
      .data_receive  (data_receive),
      .script_mode   (script_mode),
      .sig_front     (sig_front),
      .sig_hand      (sig_hand),
      .sig_processing(sig_processing),
      .sig_machine   (sig_machine),
      .feedback_leds (feedback_leds),
      .fb_update     (fb_update),
      .fb_stale      (fb_stale),
      .err_count     (err_count)
   );

   typedef struct {
      logic [7:0] data;
      logic [3:0] leds;
      logic       upd;
      logic [7:0] err;
      logic       stale;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      data_valid   = 1'b1;
      data_receive = b;
      @(negedge clock);
      data_valid   = 1'b0;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      vecs[0]  = '{8'h15, 4'b0000, 1'b0, 8'd0, 1'b0};
      vecs[1]  = '{8'h15, 4'b0101, 1'b1, 8'd0, 1'b0};
      vecs[2]  = '{8'h05, 4'b0101, 1'b0, 8'd0, 1'b0};
      vecs[3]  = '{8'h09, 4'b0101, 1'b0, 8'd0, 1'b0};
      vecs[4]  = '{8'h09, 4'b0010, 1'b1, 8'd0, 1'b0};
      vecs[5]  = '{8'h0A, 4'b0010, 1'b0, 8'd1, 1'b0};
      vecs[6]  = '{8'hC9, 4'b0010, 1'b0, 8'd1, 1'b0};
      vecs[7]  = '{8'h03, 4'b0010, 1'b0, 8'd2, 1'b0};
      vecs[8]  = '{8'h00, 4'b0010, 1'b0, 8'd3, 1'b0};
      vecs[9]  = '{8'h3D, 4'b0010, 1'b0, 8'd3, 1'b0};
      vecs[10] = '{8'hFD, 4'b1111, 1'b1, 8'd3, 1'b0};
      vecs[11] = '{8'h05, 4'b1111, 1'b0, 8'd3, 1'b0};
      vecs[12] = '{8'h09, 4'b1111, 1'b0, 8'd3, 1'b0};
      vecs[13] = '{8'h05, 4'b1111, 1'b0, 8'd3, 1'b0};
      vecs[14] = '{8'h05, 4'b0001, 1'b1, 8'd3, 1'b0};

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      tick();
      chk("rst_leds",  32'(feedback_leds), 32'h0);
      chk("rst_upd",   32'(fb_update), 32'h0);
      chk("rst_err",   32'(err_count), 32'h0);
      chk("rst_stale", 32'(fb_stale), 32'h1);

      for (int i = 0; i < 15; i++) begin
         send_byte(vecs[i].data);
         tick();
         chk($sformatf("vec%0d_leds", i), 32'(feedback_leds), 32'(vecs[i].leds));
         chk($sformatf("vec%0d_upd", i), 32'(fb_update), 32'(vecs[i].upd));
         chk($sformatf("vec%0d_err", i), 32'(err_count), 32'(vecs[i].err));
         chk($sformatf("vec%0d_stale", i), 32'(fb_stale), 32'(vecs[i].stale));
         if (vecs[i].upd) begin
            tick();
            chk($sformatf("vec%0d_pulse", i), 32'(fb_update), 32'h0);
         end
      end
      chk("sig_front", 32'(sig_front), 32'h1);
      chk("sig_hand",  32'(sig_hand), 32'h0);

      // Level held high for 5 clocks counts as a single frame
      @(negedge clock);
      data_valid   = 1'b1;
      data_receive = 8'h09;
      repeat (5) @(negedge clock);
      data_valid = 1'b0;
      repeat (3) tick();
      chk("hold_leds", 32'(feedback_leds), 32'b0001);
      send_byte(8'h09);
      tick();
      chk("hold_commit", 32'(feedback_leds), 32'b0010);
      chk("hold_upd", 32'(fb_update), 32'h1);

      // Timeout exactly at the limit
      repeat (15) tick();
      chk("to_before", 32'(fb_stale), 32'h0);
      tick();
      chk("to_at", 32'(fb_stale), 32'h1);
      chk("to_leds", 32'(feedback_leds), 32'b0010);
      send_byte(8'h09);
      tick();
      chk("to_clear", 32'(fb_stale), 32'h0);
      repeat (14) @(posedge clock);
      send_byte(8'h09);
      tick();
      chk("to_race", 32'(fb_stale), 32'h0);
      repeat (3) tick();
      chk("to_race_after", 32'(fb_stale), 32'h0);

      // Error counter saturation
      repeat (20) tick();
      chk("sat_stale_pre", 32'(fb_stale), 32'h1);
      for (int i = 0; i < 300; i++) send_byte(8'h02);
      tick();
      chk("sat_err", 32'(err_count), 32'd255);
      chk("sat_leds", 32'(feedback_leds), 32'b0010);
      chk("sat_stale", 32'(fb_stale), 32'h1);

      // Script mode: in-flight frame dropped, bytes ignored, timer frozen
      send_byte(8'h15);
      tick();
      chk("scr_track", 32'(feedback_leds), 32'b0010);
      chk("scr_stale", 32'(fb_stale), 32'h0);
      send_byte(8'h15);
      script_mode = 1'b1;
      repeat (3) send_byte(8'h05);
      repeat (20) tick();
      chk("scr_leds", 32'(feedback_leds), 32'b0010);
      chk("scr_frozen", 32'(fb_stale), 32'h0);
      chk("scr_err", 32'(err_count), 32'd255);
      @(negedge clock);
      script_mode = 1'b0;
      send_byte(8'h15);
      tick();
      chk("scr_fresh1", 32'(feedback_leds), 32'b0010);
      send_byte(8'h15);
      tick();
      chk("scr_fresh2", 32'(feedback_leds), 32'b0101);
      chk("scr_upd", 32'(fb_update), 32'h1);

      // Reset with a frame sitting in stage 1
      @(negedge clock);
      data_valid   = 1'b1;
      data_receive = 8'h09;
      @(negedge clock);
      data_valid = 1'b0;
      reset      = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid_leds",  32'(feedback_leds), 32'h0);
      chk("mid_err",   32'(err_count), 32'h0);
      chk("mid_stale", 32'(fb_stale), 32'h1);
      repeat (3) tick();
      chk("mid_after", 32'(feedback_leds), 32'h0);
      chk("mid_upd",   32'(fb_update), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
